// File: rtl/spi_regbank_fifo_if.sv
// Host register bus between the CPU-side master and the SPI register bank.
interface spi_regbank_fifo_if;
  logic [2:0] AD_i;
  logic       WR_i;
  logic       RD_i;
  logic [7:0] Data_i;
  logic [7:0] Data_o;

  modport master (output AD_i, output WR_i, output RD_i, output Data_i, input Data_o);
  modport slave  (input AD_i, input WR_i, input RD_i, input Data_i, output Data_o);
endinterface

// File: rtl/spi_regbank_fifo.sv
// SPI master register bank with TX/RX FIFOs, W1C sticky status and maskable interrupt.
// Optional DMA request outputs are built when SPI_REGBANK_DMA_EN is defined.
module spi_regbank_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int NUM_CS     = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                 CLK_i,
  input  logic                 RST_i,
  input  logic                 RST_SYNC_i,
  spi_regbank_fifo_if.slave    bus,
  output logic [DIV_WIDTH-1:0] Divisor_o,
  output logic                 SPE_o,
  output logic                 CPOL_o,
  output logic                 CPHA_o,
  output logic                 LSBFE_o,
  output logic [NUM_CS-1:0]    SPI_CS_o,
  output logic                 tx_valid_o,
  output logic [7:0]           tx_data_o,
  input  logic                 tx_ready_i,
  input  logic                 rx_valid_i,
  input  logic [7:0]           rx_data_i,
  input  logic                 xfer_done_i,
  output logic                 Busy_o,
  output logic                 INTR_o
`ifdef SPI_REGBANK_DMA_EN
  ,
  output logic                 tx_dreq_o,
  output logic                 rx_dreq_o
`endif
);

  localparam int         PW     = $clog2(FIFO_DEPTH);
  localparam logic [3:0] DEPTH_L = 4'(FIFO_DEPTH);
  localparam logic [3:0] HALF_L  = 4'(FIFO_DEPTH / 2);

  typedef struct packed {
    logic [DIV_WIDTH-1:0] div;
    logic                 spe;
    logic                 ie;
    logic                 cpol;
    logic                 cpha;
    logic                 lsbfe;
    logic [NUM_CS-1:0]    cs;
    logic [7:0]           imask;
    logic [PW-1:0]        tx_wptr;
    logic [PW-1:0]        tx_rptr;
    logic [PW-1:0]        rx_wptr;
    logic [PW-1:0]        rx_rptr;
    logic [3:0]           tx_level;
    logic [3:0]           rx_level;
    logic                 txovr;
    logic                 rxovr;
    logic                 done;
    logic                 busy;
    logic                 intr;
    logic [7:0]           data_o;
`ifdef SPI_REGBANK_DMA_EN
    logic                 tx_dreq;
    logic                 rx_dreq;
`endif
  } regs_t;

  function automatic regs_t f_reset_val();
    regs_t v;
    v     = '0;
    v.div = DIV_WIDTH'(1);
    return v;
  endfunction

  regs_t      r_st;
  regs_t      w_nx;
  logic [7:0] r_tx_mem [FIFO_DEPTH];
  logic [7:0] r_rx_mem [FIFO_DEPTH];

  logic       w_tx_empty, w_tx_full, w_rx_empty, w_rx_full;
  logic       w_tx_wr, w_tx_push, w_tx_pop, w_tx_ovr;
  logic       w_rx_push, w_rx_pop, w_rx_ovr;
  logic       w_flush;
  logic [7:0] w_clr;
  logic [7:0] w_status;
  logic [7:0] w_imask_ext;
  logic [7:0] w_ctrl;
  logic [15:0] w_div16;
  logic [7:0] w_rdata;

  assign w_tx_empty = (r_st.tx_level == 4'd0);
  assign w_tx_full  = (r_st.tx_level == DEPTH_L);
  assign w_rx_empty = (r_st.rx_level == 4'd0);
  assign w_rx_full  = (r_st.rx_level == DEPTH_L);

  assign tx_valid_o = r_st.spe & ~w_tx_empty;
  assign tx_data_o  = r_tx_mem[r_st.tx_rptr];

  // A push into a full TX FIFO survives when the engine pops the head in the same cycle
  assign w_tx_pop  = tx_valid_o & tx_ready_i;
  assign w_tx_wr   = bus.WR_i & (bus.AD_i == 3'd3);
  assign w_tx_push = w_tx_wr & (~w_tx_full | w_tx_pop);
  assign w_tx_ovr  = w_tx_wr & w_tx_full & ~w_tx_pop;

  assign w_rx_push = rx_valid_i & ~w_rx_full;
  assign w_rx_ovr  = rx_valid_i & w_rx_full;
  assign w_rx_pop  = bus.RD_i & (bus.AD_i == 3'd3) & ~w_rx_empty;

  assign w_flush = bus.WR_i & (bus.AD_i == 3'd2) & ~bus.Data_i[7];
  assign w_clr   = (bus.WR_i && bus.AD_i == 3'd4) ? bus.Data_i : 8'h00;

  assign w_status    = {r_st.txovr, r_st.rxovr, r_st.done, r_st.busy,
                        w_rx_full, w_tx_full, w_tx_empty, ~w_rx_empty};
  assign w_imask_ext = {r_st.imask[7], r_st.imask[7], r_st.imask[5], 1'b0,
                        r_st.imask[3], 1'b0, r_st.imask[1], r_st.imask[0]};
  assign w_ctrl      = {r_st.spe, r_st.ie, 2'b00, r_st.cpol, r_st.cpha, 1'b0, r_st.lsbfe};
  assign w_div16     = 16'(r_st.div);

  always_comb begin
    w_rdata = 8'h00;
    case (bus.AD_i)
      3'd0: w_rdata = w_div16[7:0];
      3'd1: w_rdata = w_div16[15:8];
      3'd2: w_rdata = w_ctrl;
      3'd3: w_rdata = w_rx_empty ? 8'h00 : r_rx_mem[r_st.rx_rptr];
      3'd4: w_rdata = w_status;
      3'd5: w_rdata = 8'(r_st.cs);
      3'd6: w_rdata = r_st.imask;
      3'd7: w_rdata = {r_st.tx_level, r_st.rx_level};
      default: w_rdata = 8'h00;
    endcase
  end

  always_comb begin
    w_nx = r_st;

    if (bus.WR_i) begin
      case (bus.AD_i)
        3'd0: w_nx.div[7:0] = bus.Data_i;
        3'd1: w_nx.div = {bus.Data_i[DIV_WIDTH-9:0], r_st.div[7:0]};
        3'd2: begin
          w_nx.spe   = bus.Data_i[7];
          w_nx.ie    = bus.Data_i[6];
          w_nx.cpol  = bus.Data_i[3];
          w_nx.cpha  = bus.Data_i[2];
          w_nx.lsbfe = bus.Data_i[0];
        end
        3'd5: w_nx.cs = bus.Data_i[NUM_CS-1:0];
        3'd6: w_nx.imask = bus.Data_i & 8'hAB;
        default: ;
      endcase
    end

    if (w_flush) begin
      w_nx.tx_wptr  = '0;
      w_nx.tx_rptr  = '0;
      w_nx.tx_level = 4'd0;
      w_nx.rx_wptr  = '0;
      w_nx.rx_rptr  = '0;
      w_nx.rx_level = 4'd0;
    end else begin
      if (w_tx_push) w_nx.tx_wptr = r_st.tx_wptr + PW'(1);
      if (w_tx_pop)  w_nx.tx_rptr = r_st.tx_rptr + PW'(1);
      w_nx.tx_level = r_st.tx_level + 4'(w_tx_push) - 4'(w_tx_pop);
      if (w_rx_push) w_nx.rx_wptr = r_st.rx_wptr + PW'(1);
      if (w_rx_pop)  w_nx.rx_rptr = r_st.rx_rptr + PW'(1);
      w_nx.rx_level = r_st.rx_level + 4'(w_rx_push) - 4'(w_rx_pop);
    end

    // Hardware set dominates a same-cycle write-1-to-clear
    w_nx.txovr = (r_st.txovr & ~w_clr[7]) | w_tx_ovr;
    w_nx.rxovr = (r_st.rxovr & ~w_clr[6]) | w_rx_ovr;
    w_nx.done  = (r_st.done  & ~w_clr[5]) | xfer_done_i;

    if (w_tx_pop)
      w_nx.busy = 1'b1;
    else if (xfer_done_i && w_tx_empty)
      w_nx.busy = 1'b0;

    w_nx.intr   = r_st.spe & r_st.ie & (|(w_status & w_imask_ext));
    w_nx.data_o = w_rdata;
`ifdef SPI_REGBANK_DMA_EN
    w_nx.tx_dreq = r_st.spe & (r_st.tx_level <= HALF_L);
    w_nx.rx_dreq = r_st.spe & ~w_rx_empty;
`endif
  end

  always_ff @(posedge CLK_i or posedge RST_i) begin
    if (RST_i)
      r_st <= f_reset_val();
    else if (RST_SYNC_i)
      r_st <= f_reset_val();
    else
      r_st <= w_nx;
  end

  // Storage is not reset; the pointers and levels decide what is valid
  always_ff @(posedge CLK_i) begin
    if (w_tx_push) r_tx_mem[r_st.tx_wptr] <= bus.Data_i;
    if (w_rx_push) r_rx_mem[r_st.rx_wptr] <= rx_data_i;
  end

  assign bus.Data_o = r_st.data_o;
  assign Divisor_o  = r_st.div;
  assign SPE_o      = r_st.spe;
  assign CPOL_o     = r_st.cpol;
  assign CPHA_o     = r_st.cpha;
  assign LSBFE_o    = r_st.lsbfe;
  assign SPI_CS_o   = r_st.cs;
  assign Busy_o     = r_st.busy;
  assign INTR_o     = r_st.intr;
`ifdef SPI_REGBANK_DMA_EN
  assign tx_dreq_o  = r_st.tx_dreq;
  assign rx_dreq_o  = r_st.rx_dreq;
`endif

endmodule

// File: tb/tb_spi_regbank_fifo.sv
// Directed bench for spi_regbank_fifo; register reads are checked through an expected-value queue.
module tb_spi_regbank_fifo;
  logic        CLK_i = 1'b0;
  logic        RST_i;
  logic        RST_SYNC_i;
  logic [15:0] Divisor_o;
  logic        SPE_o, CPOL_o, CPHA_o, LSBFE_o;
  logic [7:0]  SPI_CS_o;
  logic        tx_valid_o;
  logic [7:0]  tx_data_o;
  logic        tx_ready_i;
  logic        rx_valid_i;
  logic [7:0]  rx_data_i;
  logic        xfer_done_i;
  logic        Busy_o;
  logic        INTR_o;
`ifdef SPI_REGBANK_DMA_EN
  logic        tx_dreq_o, rx_dreq_o;
`endif

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  spi_regbank_fifo_if bus ();

  spi_regbank_fifo #(.FIFO_DEPTH(4), .NUM_CS(8), .DIV_WIDTH(16)) dut (
    .CLK_i(CLK_i), .RST_i(RST_i), .RST_SYNC_i(RST_SYNC_i), .bus(bus),
    .Divisor_o(Divisor_o), .SPE_o(SPE_o), .CPOL_o(CPOL_o), .CPHA_o(CPHA_o),
    .LSBFE_o(LSBFE_o), .SPI_CS_o(SPI_CS_o), .tx_valid_o(tx_valid_o),
    .tx_data_o(tx_data_o), .tx_ready_i(tx_ready_i), .rx_valid_i(rx_valid_i),
    .rx_data_i(rx_data_i), .xfer_done_i(xfer_done_i), .Busy_o(Busy_o),
    .INTR_o(INTR_o)
`ifdef SPI_REGBANK_DMA_EN
    , .tx_dreq_o(tx_dreq_o), .rx_dreq_o(rx_dreq_o)
`endif
  );

  always #5 CLK_i = ~CLK_i;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "bench timeout");
  end

  task automatic tick();
    @(posedge CLK_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    bus.AD_i   = a;
    bus.Data_i = d;
    bus.WR_i   = 1'b1;
    tick();
    bus.WR_i   = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [7:0] e, input string tag);
    bus.AD_i = a;
    bus.RD_i = (a == 3'd3);
    exp_q.push_back(e);
    tick();
    bus.RD_i = 1'b0;
    chk(tag, 16'(bus.Data_o), 16'(exp_q.pop_front()));
  endtask

  task automatic rxb(input logic [7:0] d);
    rx_valid_i = 1'b1;
    rx_data_i  = d;
    tick();
    rx_valid_i = 1'b0;
  endtask

  initial begin
    RST_i = 1'b1; RST_SYNC_i = 1'b0;
    bus.AD_i = 3'd0; bus.WR_i = 1'b0; bus.RD_i = 1'b0; bus.Data_i = 8'h00;
    tx_ready_i = 1'b0; rx_valid_i = 1'b0; rx_data_i = 8'h00; xfer_done_i = 1'b0;
    tick(); tick();
    chk("rst_txvalid", 16'(tx_valid_o), 16'h0);
    chk("rst_cs", 16'(SPI_CS_o), 16'h0);
    chk("rst_div", Divisor_o, 16'h0001);
    chk("rst_intr", 16'(INTR_o), 16'h0);
    chk("rst_busy", 16'(Busy_o), 16'h0);
    RST_i = 1'b0;

    // Reset read-back of the whole map
    rd(3'd0, 8'h01, "rd_div_lo");
    rd(3'd1, 8'h00, "rd_div_hi");
    rd(3'd2, 8'h00, "rd_ctrl");
    rd(3'd3, 8'h00, "rd_rx_empty");
    rd(3'd4, 8'h02, "rd_status");
    rd(3'd5, 8'h00, "rd_cs");
    rd(3'd6, 8'h00, "rd_imask");
    rd(3'd7, 8'h00, "rd_level");

    // Configuration
    wr(3'd0, 8'h34);
    wr(3'd1, 8'h12);
    chk("divisor", Divisor_o, 16'h1234);
    wr(3'd5, 8'hA5);
    chk("cs_out", 16'(SPI_CS_o), 16'h00A5);
    wr(3'd2, 8'hBF);
    rd(3'd2, 8'h8D, "ctrl_unstored_bits");
    chk("mode_bits", 16'({SPE_o, CPOL_o, CPHA_o, LSBFE_o}), 16'hF);
    wr(3'd2, 8'h80);

    // TX fill and overflow
    wr(3'd3, 8'hA1);
    chk("txvalid_after_push", 16'(tx_valid_o), 16'h1);
    wr(3'd3, 8'hA2);
    wr(3'd3, 8'hA3);
    wr(3'd3, 8'hA4);
    wr(3'd3, 8'hA5);
    rd(3'd7, 8'h40, "level_tx_full");
    rd(3'd4, 8'h84, "status_txovr_txf");
    chk("tx_head", 16'(tx_data_o), 16'h00A1);
    tx_ready_i = 1'b1;
    tick();
    tx_ready_i = 1'b0;
    chk("tx_head_after_pop", 16'(tx_data_o), 16'h00A2);
    chk("busy_after_pop", 16'(Busy_o), 16'h1);
    rd(3'd7, 8'h30, "level_after_pop");
    wr(3'd4, 8'h80);
    rd(3'd4, 8'h10, "status_txovr_cleared");

    // RX fill, overflow and drain
    for (int i = 0; i < 5; i++) rxb(8'h11 + 8'(i));
    rd(3'd4, 8'h59, "status_rx_full_ovr");
    rd(3'd7, 8'h34, "level_rx_full");
    for (int i = 0; i < 4; i++) rd(3'd3, 8'h11 + 8'(i), "rx_pop");
    rd(3'd3, 8'h00, "rx_pop_empty");
    rd(3'd4, 8'h50, "status_rx_drained");
    wr(3'd4, 8'h40);

    // Interrupt on DONE
    wr(3'd2, 8'hC0);
    wr(3'd6, 8'h20);
    xfer_done_i = 1'b1;
    tick();
    xfer_done_i = 1'b0;
    chk("intr_one_edge", 16'(INTR_o), 16'h0);
    tick();
    chk("intr_two_edges", 16'(INTR_o), 16'h1);
    chk("busy_tx_not_empty", 16'(Busy_o), 16'h1);
    bus.AD_i = 3'd4; bus.Data_i = 8'h20; bus.WR_i = 1'b1; xfer_done_i = 1'b1;
    tick();
    bus.WR_i = 1'b0; xfer_done_i = 1'b0;
    rd(3'd4, 8'h30, "done_set_beats_clear");
    chk("intr_held", 16'(INTR_o), 16'h1);
    wr(3'd4, 8'h20);
    tick();
    chk("intr_cleared", 16'(INTR_o), 16'h0);
    rd(3'd4, 8'h10, "status_done_cleared");

    // Push into full TX with a simultaneous pop
    wr(3'd3, 8'hB1);
    rd(3'd7, 8'h40, "level_full_again");
    tx_ready_i = 1'b1;
    wr(3'd3, 8'hB2);
    tx_ready_i = 1'b0;
    rd(3'd7, 8'h40, "level_push_pop_full");
    rd(3'd4, 8'h14, "status_no_txovr");
    chk("tx_head_a3", 16'(tx_data_o), 16'h00A3);

    // Async reset with FIFOs half full
    tx_ready_i = 1'b1;
    tick(); tick();
    tx_ready_i = 1'b0;
    chk("tx_head_b1", 16'(tx_data_o), 16'h00B1);
    rd(3'd7, 8'h20, "level_tx_half");
    rxb(8'h21);
    rxb(8'h22);
    rd(3'd7, 8'h22, "level_both_half");
    wr(3'd6, 8'h01);
    bus.AD_i = 3'd0;
    tick(); tick();
    chk("intr_rxne", 16'(INTR_o), 16'h1);
    chk("data_o_pre_reset", 16'(bus.Data_o), 16'h0034);
    RST_i = 1'b1;
    #1;
    chk("arst_txvalid", 16'(tx_valid_o), 16'h0);
    chk("arst_cs", 16'(SPI_CS_o), 16'h0);
    chk("arst_intr", 16'(INTR_o), 16'h0);
    chk("arst_busy", 16'(Busy_o), 16'h0);
    chk("arst_data_o", 16'(bus.Data_o), 16'h0);
    chk("arst_div", Divisor_o, 16'h0001);
    chk("arst_spe", 16'(SPE_o), 16'h0);
    tick();
    RST_i = 1'b0;
    rd(3'd7, 8'h00, "level_after_arst");
    rd(3'd4, 8'h02, "status_after_arst");

    // Synchronous reset and SPE=0 flush
    wr(3'd5, 8'h0F);
    chk("cs_0f", 16'(SPI_CS_o), 16'h000F);
    RST_SYNC_i = 1'b1;
    tick();
    RST_SYNC_i = 1'b0;
    chk("srst_cs", 16'(SPI_CS_o), 16'h0);
    wr(3'd2, 8'h80);
    wr(3'd3, 8'h55);
    wr(3'd3, 8'h66);
    rxb(8'h77);
    rd(3'd7, 8'h21, "level_before_flush");
    wr(3'd2, 8'h00);
    rd(3'd7, 8'h00, "level_after_flush");
    chk("txvalid_after_flush", 16'(tx_valid_o), 16'h0);

`ifdef SPI_REGBANK_DMA_EN
    wr(3'd2, 8'h80);
    wr(3'd3, 8'h01);
    wr(3'd3, 8'h02);
    wr(3'd3, 8'h03);
    tick();
    chk("tx_dreq_level3", 16'(tx_dreq_o), 16'h0);
    chk("rx_dreq_empty", 16'(rx_dreq_o), 16'h0);
    tx_ready_i = 1'b1;
    tick();
    tx_ready_i = 1'b0;
    tick();
    chk("tx_dreq_level2", 16'(tx_dreq_o), 16'h1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spi_regbank_fifo.md
# spi_regbank_fifo

Parametrised SPI master register bank that sits between the 8-bit host register bus and the SPI shift engine. It replaces single-byte TX/RX holding registers with TX and RX FIFOs, a parametrised slave-select width, and maskable interrupts whose sticky status bits are cleared by writing 1. Divisor, mode and chip-select configuration go to the shift engine. TX bytes are handed off with a valid/ready handshake.

## Interface
- FIFO_DEPTH, 4, entries per TX and RX FIFO; power of 2, 2..8
- NUM_CS, 8, slave-select outputs, 1..8
- DIV_WIDTH, 16, baud divisor width, 9..16
- CLK_i  in  1  clock
- RST_i  in  1  reset, asynchronous, active-high
- RST_SYNC_i  in  1  synchronous reset; same effect as RST_i at the next edge
- AD_i  in  3  register address
- WR_i  in  1  write strobe
- RD_i  in  1  read strobe; only needed to pop RX FIFO
- Data_i  in  8  write data
- Data_o  out  8  registered read data
- Divisor_o  out  DIV_WIDTH  baud divisor
- SPE_o, CPOL_o, CPHA_o, LSBFE_o  out  1 each  CTRL[7], CTRL[3], CTRL[2], CTRL[0]
- SPI_CS_o  out  NUM_CS  CS register bits [NUM_CS-1:0]
- tx_valid_o  out  1  SPE & TX FIFO not empty
- tx_data_o  out  8  TX FIFO head (combinational from storage)
- tx_ready_i  in  1  engine takes head; a pop occurs when tx_valid_o & tx_ready_i
- rx_valid_i  in  1  one-cycle pulse, received byte on rx_data_i
- rx_data_i  in  8  received byte
- xfer_done_i  in  1  one-cycle pulse, byte transfer finished
- Busy_o  out  1  transfer in progress
- INTR_o  out  1  registered interrupt

## Operation
Address map; writes take effect at the WR_i edge:
- 0 DIV[7:0]; 1 DIV[DIV_WIDTH-1:8], upper unused bits read 0.
- 2 CTRL {SPE,IE,0,0,CPOL,CPHA,0,LSBFE}. Bits 5,4,1 are not stored.
- Writing CTRL with SPE=0 flushes both FIFOs.
- 3 write pushes TX; read with RD_i pops RX.
- 4 STATUS {TXOVR,RXOVR,DONE,BUSY,RXF,TXF,TXE,RXNE}, bits [7:0].
  - Writing 1 to TXOVR, RXOVR or DONE clears that bit. Other bits are read-only.
- 5 CS.
- 6 IMASK {0,0,DONE,0,RXF,0,TXE,RXNE} enables, plus bit7 = enable for both OVR flags.
- 7 LEVEL {tx_level[3:0], rx_level[3:0]}.

Reset values:
- DIV = 1, CTRL = 0, CS = 0, IMASK = 0.
- FIFOs empty, sticky flags 0, Busy_o = 0, INTR_o = 0, Data_o = 0.
- Resulting outputs: tx_valid_o = 0, SPI_CS_o = 0.

FIFO rules:
- TX push when full is dropped and sets TXOVR, unless a pop occurs in the same cycle; then it is accepted and the level is unchanged.
- rx_valid_i when RX is full drops the byte and sets RXOVR; stored data is unchanged.
- RD_i at address 3 with RX empty returns 0x00 and changes no state.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally. Levels are 0..FIFO_DEPTH.

Flag and status rules:
- If a hardware set and a W1C clear hit the same flag in the same cycle, the set wins.
- Busy_o sets on a TX pop and clears on xfer_done_i when the TX FIFO is empty with no pop that cycle. Otherwise it stays set.
- DONE sets on xfer_done_i.

Interrupt:
- INTR_o <= SPE & IE & |(STATUS & IMASK), where IMASK bit7 covers both OVR flags.

Reset behaviour:
- RST_SYNC_i or RST_i mid-transfer returns every register to its reset value and drops FIFO contents. The engine sees tx_valid_o fall in the same cycle.

## Timing
- Data_o <= mux(AD_i) every edge, giving 1-cycle read latency. The RX pop happens at the same edge, so Data_o shows the pre-pop head.
- STATUS, LEVEL and INTR_o reflect events one cycle after the event edge.
- A TX push is visible on tx_valid_o in the next cycle.
- An RX byte is readable starting with the read issued the cycle after the rx_valid_i edge.

## Configuration
- SPI_REGBANK_DMA_EN defined: adds output tx_dreq_o = SPE & (tx_level <= FIFO_DEPTH/2) and output rx_dreq_o = SPE & RXNE. Both are registered and reset to 0.
- SPI_REGBANK_DMA_EN undefined: these ports and their logic are absent. All other behaviour is identical.

## Test plan
- Reset, then read addresses 0..7 -> 0x01,0x00,0x00,0x00,0x02,0x00,0x00,0x00 (TXE=1; LEVEL=0x00).
- CTRL=0x80, push 0xA1..0xA4 (depth 4), then push 0xA5 -> LEVEL=0x40, TXF=1, TXOVR=1, tx_data_o=0xA1. Pulse tx_ready_i -> tx_data_o=0xA2, Busy_o=1.
- Five rx_valid_i pulses carrying 0x11..0x15 -> RXF=1, RXOVR=1. Four RD_i reads at address 3 -> 0x11..0x14. A fifth read -> 0x00, RXNE=0.
- CTRL=0xC0, IMASK=0x20, pulse xfer_done_i -> INTR_o=1 two edges later. Write 0x20 to STATUS in the same cycle as another xfer_done_i -> DONE stays 1. A lone clear -> INTR_o=0.
- Push while full with simultaneous pop -> accepted, LEVEL unchanged, TXOVR=0. Assert RST_i with FIFOs half full -> all outputs at reset values immediately.
- With SPI_REGBANK_DMA_EN: push 3 bytes at depth 4 -> tx_dreq_o=0. Pop 1 -> tx_dreq_o=1.
